// File: rtl/spi_pkg.sv
// SPI shared definitions: word width, synchronizer depth and word type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    localparam int SPI_WORD_W      = 16;
    localparam int SPI_SYNC_STAGES = 2;

    typedef logic [SPI_WORD_W-1:0] spi_word_t;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with a selectable reset value.
// Latency: DEPTH clk cycles from d to q.
// Backpressure: none; free-running every clk.
//
// Ports: clk, reset (sync, active-high), d (async input), q (synchronized).
module sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {DEPTH{RST_VAL}};
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 slave receiver: oversamples sclk/sel/mosi, assembles MSB-first words.
// Latency: word presented a few clk cycles after the last sclk rising edge.
// Backpressure: one held word; a word completing while it is still held is dropped (overrun).
//
// Ports: clk, reset (sync, active-high), sclk/sel/mosi (async SPI inputs, sel active low),
//        ready_in (downstream accept), data_out/valid_out (output word), overrun/frame_err (pulses).
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_WORD_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              sel,
    input  logic              mosi,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W);

    logic              sclk_s;
    logic              sel_s;
    logic              mosi_s;
    logic              sclk_d;
    logic              sel_d;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;

    logic              rise;
    logic              sample;
    logic              sel_rise;
    logic              last_bit;
    logic              complete;
    logic [DATA_W-1:0] word;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_s)
    );

    // Chip select resets to the idle (deasserted) level so that reset never
    // looks like the start of a frame.
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sel (
        .clk(clk), .reset(reset), .d(sel), .q(sel_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi), .q(mosi_s)
    );

    assign rise     = sclk_s && !sclk_d;
    // sel_s gates the edge, so a rise in the same cycle as deselect is ignored.
    assign sample   = rise && !sel_s;
    assign sel_rise = sel_s && !sel_d;
    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
    assign complete = sample && last_bit;
    assign word     = {shift[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_d    <= 1'b0;
            sel_d     <= 1'b1;
            shift     <= '0;
            bit_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            sel_d  <= sel_s;

            if (sample) begin
                shift   <= word;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end else if (sel_s) begin
                bit_cnt <= '0;
            end

            // sample needs sel_s low and sel_rise needs it high, so the two
            // error pulses are mutually exclusive by construction.
            frame_err <= sel_rise && (bit_cnt != '0);

            if (complete && (!valid_out || ready_in)) begin
                data_out  <= word;
                valid_out <= 1'b1;
                overrun   <= 1'b0;
            end else begin
                overrun <= complete;
                if (ready_in) begin
                    valid_out <= 1'b0;
                end
            end
        end
    end

endmodule
